// File: rtl/state_log_sequencer.sv
// Arm/capture/freeze sequencer for a bank of single-reference state loggers.
// Define STATE_LOG_SECOND_FAULT_EN to also latch the first new channel seen during HOLD.
module state_log_sequencer #(
    parameter int CHANNELS = 4,
    parameter int TS_BITS  = 16,
    parameter int ARM_DLY  = 8,
    parameter int HOLD_CYC = 4
) (
    input  logic                iClk,
    input  logic                iRst_n,
    input  logic                iArm,
    input  logic                iClrReq,
    input  logic [CHANNELS-1:0] iChange,
    output logic                oClear_n,
    output logic                oEnable,
    output logic [CHANNELS-1:0] oFirstCh,
    output logic [TS_BITS-1:0]  oTimestamp,
    output logic                oFrozen,
    output logic                oClrAck,
    output logic [2:0]          oState,
    output logic [CHANNELS-1:0] oSecondCh,
    output logic [TS_BITS-1:0]  oSecondTs
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        SETTLE = 3'd2,
        ARMED  = 3'd3,
        HOLD   = 3'd4,
        FROZEN = 3'd5
    } state_t;

    // One counter serves both the SETTLE delay and the HOLD window.
    localparam int CNT_MAX = (ARM_DLY > HOLD_CYC) ? ARM_DLY : HOLD_CYC;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] ARM_LAST  = CW'(ARM_DLY - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
    localparam logic [TS_BITS-1:0] TS_MAX = '1;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [TS_BITS-1:0]  ts_q, ts_d, ts_inc;
    logic [CHANNELS-1:0] first_q, first_d;
    logic [TS_BITS-1:0]  fts_q, fts_d;
    logic                ack_q, ack_d;
    logic                clear_n_q, clear_n_d;
    logic                en_q, en_d;
    logic                frozen_q, frozen_d;
    logic                clr_ok;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ts_d    = ts_q;
        first_d = first_q;
        fts_d   = fts_q;
        ack_d   = 1'b0;
        ts_inc  = (ts_q == TS_MAX) ? ts_q : ts_q + 1'b1;
        clr_ok  = iClrReq && (state_q == SETTLE || state_q == ARMED ||
                              state_q == HOLD   || state_q == FROZEN);
        if (clr_ok) begin
            ack_d   = 1'b1;
            state_d = CLEAR;
        end else begin
            case (state_q)
                IDLE: begin
                    if (iClrReq)   ack_d   = 1'b1;
                    else if (iArm) state_d = CLEAR;
                end
                CLEAR: begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end
                SETTLE: begin
                    if (!iArm)                  state_d = IDLE;
                    else if (cnt_q == ARM_LAST) state_d = ARMED;
                    else                        cnt_d   = cnt_q + 1'b1;
                end
                ARMED: begin
                    ts_d = ts_inc;
                    // A capture wins over a dropped arm in the same cycle.
                    if (|iChange) begin
                        first_d = iChange;
                        fts_d   = ts_q;
                        cnt_d   = '0;
                        state_d = (HOLD_CYC == 0) ? FROZEN : HOLD;
                    end else if (!iArm) begin
                        state_d = IDLE;
                    end
                end
                HOLD: begin
                    ts_d = ts_inc;
                    if (cnt_q == HOLD_LAST) state_d = FROZEN;
                    else                    cnt_d   = cnt_q + 1'b1;
                end
                FROZEN: ;
                default: state_d = IDLE;
            endcase
        end
        if (state_d == CLEAR) begin
            ts_d    = '0;
            first_d = '0;
            fts_d   = '0;
        end
        clear_n_d = !(state_d == IDLE || state_d == CLEAR);
        en_d      = (state_d == ARMED || state_d == HOLD);
        frozen_d  = (state_d == FROZEN);
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ts_q      <= '0;
            first_q   <= '0;
            fts_q     <= '0;
            ack_q     <= 1'b0;
            clear_n_q <= 1'b0;
            en_q      <= 1'b0;
            frozen_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ts_q      <= ts_d;
            first_q   <= first_d;
            fts_q     <= fts_d;
            ack_q     <= ack_d;
            clear_n_q <= clear_n_d;
            en_q      <= en_d;
            frozen_q  <= frozen_d;
        end
    end

`ifdef STATE_LOG_SECOND_FAULT_EN
    logic [CHANNELS-1:0] sec_q, sec_d, fresh;
    logic [TS_BITS-1:0]  sts_q, sts_d;

    // Nonzero sec_q doubles as the "already latched" flag.
    always_comb begin
        sec_d = sec_q;
        sts_d = sts_q;
        fresh = iChange & ~first_q;
        if (state_d == CLEAR) begin
            sec_d = '0;
            sts_d = '0;
        end else if (state_q == HOLD && sec_q == '0 && |fresh) begin
            sec_d = fresh;
            sts_d = ts_q;
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            sec_q <= '0;
            sts_q <= '0;
        end else begin
            sec_q <= sec_d;
            sts_q <= sts_d;
        end
    end

    assign oSecondCh = sec_q;
    assign oSecondTs = sts_q;
`else
    assign oSecondCh = '0;
    assign oSecondTs = '0;
`endif

    assign oClear_n   = clear_n_q;
    assign oEnable    = en_q;
    assign oFirstCh   = first_q;
    assign oTimestamp = fts_q;
    assign oFrozen    = frozen_q;
    assign oClrAck    = ack_q;
    assign oState     = state_q;
endmodule

// File: tb/tb_state_log_sequencer.sv
// Bench for state_log_sequencer: directed scenario tasks plus random stimulus
// checked every cycle against a countdown-based reference model.
module tb_state_log_sequencer;
    localparam int CH = 4, TSB = 16, AD = 8, HC = 4;
    localparam int TSMAX = (1 << TSB) - 1;

    logic iClk = 1'b0, iRst_n = 1'b0, iArm = 1'b0, iClrReq = 1'b0;
    logic [CH-1:0] iChange = '0;
    logic oClear_n, oEnable, oFrozen, oClrAck;
    logic [CH-1:0] oFirstCh, oSecondCh;
    logic [TSB-1:0] oTimestamp, oSecondTs;
    logic [2:0] oState;
    logic t4_clear_n, t4_en, t4_frozen, t4_ack;
    logic [CH-1:0] t4_first, t4_sec;
    logic [3:0] t4_ts, t4_sts;
    logic [2:0] t4_state;

    int vecs = 0, errs = 0;

    state_log_sequencer #(.CHANNELS(CH), .TS_BITS(TSB), .ARM_DLY(AD), .HOLD_CYC(HC)) dut (
        .iClk(iClk), .iRst_n(iRst_n), .iArm(iArm), .iClrReq(iClrReq), .iChange(iChange),
        .oClear_n(oClear_n), .oEnable(oEnable), .oFirstCh(oFirstCh), .oTimestamp(oTimestamp),
        .oFrozen(oFrozen), .oClrAck(oClrAck), .oState(oState),
        .oSecondCh(oSecondCh), .oSecondTs(oSecondTs));

    state_log_sequencer #(.CHANNELS(CH), .TS_BITS(4), .ARM_DLY(AD), .HOLD_CYC(HC)) dut4 (
        .iClk(iClk), .iRst_n(iRst_n), .iArm(iArm), .iClrReq(iClrReq), .iChange(iChange),
        .oClear_n(t4_clear_n), .oEnable(t4_en), .oFirstCh(t4_first), .oTimestamp(t4_ts),
        .oFrozen(t4_frozen), .oClrAck(t4_ack), .oState(t4_state),
        .oSecondCh(t4_sec), .oSecondTs(t4_sts));

    always #5 iClk = ~iClk;

    // Reference model: phase number, countdowns and integer timestamps.
    int m_st, m_cnt, m_ts, m_fts, m_sts;
    logic m_ack;
    logic [CH-1:0] m_first, m_sec;

    task automatic model_reset();
        m_st = 0; m_cnt = 0; m_ts = 0; m_fts = 0; m_sts = 0;
        m_ack = 1'b0; m_first = '0; m_sec = '0;
    endtask

    task automatic model_clear();
        m_st = 1; m_ts = 0; m_first = '0; m_fts = 0; m_sec = '0; m_sts = 0;
    endtask

    task automatic model_tick();
        m_ack = 1'b0;
        if (iClrReq && m_st >= 2 && m_st <= 5) begin
            m_ack = 1'b1;
            model_clear();
        end else begin
            case (m_st)
                0: if (iClrReq) m_ack = 1'b1; else if (iArm) model_clear();
                1: begin m_st = 2; m_cnt = AD; end
                2: if (!iArm) m_st = 0;
                   else begin m_cnt--; if (m_cnt == 0) m_st = 3; end
                3: begin
                    if (iChange != 0) begin
                        m_first = iChange; m_fts = m_ts; m_cnt = HC;
                        m_st = (HC == 0) ? 5 : 4;
                    end else if (!iArm) m_st = 0;
                    if (m_ts < TSMAX) m_ts++;
                end
                4: begin
`ifdef STATE_LOG_SECOND_FAULT_EN
                    if (m_sec == 0 && (iChange & ~m_first) != 0) begin
                        m_sec = iChange & ~m_first; m_sts = m_ts;
                    end
`endif
                    if (m_ts < TSMAX) m_ts++;
                    m_cnt--;
                    if (m_cnt == 0) m_st = 5;
                end
                default: ;
            endcase
        end
    endtask

    task automatic step();
        model_tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic do_reset();
        iRst_n = 1'b0; iArm = 1'b0; iClrReq = 1'b0; iChange = '0;
        model_reset();
        @(posedge iClk);
        @(negedge iClk);
        iRst_n = 1'b1;
    endtask

    task automatic go_armed();
        iArm = 1'b1;
        for (int i = 0; i < 1 + AD + 1; i++) step();
    endtask

    task automatic test_reset();
        do_reset();
        vecs++;
        if ({oState, oClear_n, oEnable, oFirstCh, oTimestamp, oFrozen, oClrAck, oSecondCh, oSecondTs} !== '0) begin
            errs++;
            $display("FAIL reset_state: got st=%0d clrn=%b en=%b first=%h ts=%0d frz=%b ack=%b sec=%h sts=%0d, want all 0",
                     oState, oClear_n, oEnable, oFirstCh, oTimestamp, oFrozen, oClrAck, oSecondCh, oSecondTs);
        end
    endtask

    task automatic test_arm_seq();
        do_reset();
        iArm = 1'b1;
        step();
        vecs++;
        if ({oState, oClear_n, oEnable} !== {3'd1, 1'b0, 1'b0}) begin
            errs++; $display("FAIL arm_clear: got st=%0d clrn=%b en=%b want 1/0/0", oState, oClear_n, oEnable);
        end
        for (int i = 0; i < AD; i++) begin
            step();
            vecs++;
            if ({oState, oClear_n, oEnable} !== {3'd2, 1'b1, 1'b0}) begin
                errs++; $display("FAIL arm_settle[%0d]: got st=%0d clrn=%b en=%b want 2/1/0", i, oState, oClear_n, oEnable);
            end
        end
        step();
        vecs++;
        if ({oState, oClear_n, oEnable} !== {3'd3, 1'b1, 1'b1}) begin
            errs++; $display("FAIL arm_armed: got st=%0d clrn=%b en=%b want 3/1/1", oState, oClear_n, oEnable);
        end
    endtask

    task automatic test_capture();
        for (int i = 0; i < 25; i++) step();
        iChange = 4'b0100;
        step();
        iChange = '0;
        vecs++;
        if ({oState, oFirstCh, oTimestamp, oEnable} !== {3'd4, 4'b0100, 16'd25, 1'b1}) begin
            errs++; $display("FAIL capture: got st=%0d first=%b ts=%0d en=%b want 4/0100/25/1", oState, oFirstCh, oTimestamp, oEnable);
        end
        for (int i = 0; i < HC - 1; i++) begin
            step();
            vecs++;
            if ({oState, oEnable, oFrozen} !== {3'd4, 1'b1, 1'b0}) begin
                errs++; $display("FAIL hold[%0d]: got st=%0d en=%b frz=%b want 4/1/0", i, oState, oEnable, oFrozen);
            end
        end
        step();
        iChange = 4'b1111;
        vecs++;
        if ({oState, oEnable, oFrozen, oClear_n} !== {3'd5, 1'b0, 1'b1, 1'b1}) begin
            errs++; $display("FAIL frozen: got st=%0d en=%b frz=%b clrn=%b want 5/0/1/1", oState, oEnable, oFrozen, oClear_n);
        end
        step();
        iChange = '0;
        vecs++;
        if ({oState, oFirstCh, oTimestamp} !== {3'd5, 4'b0100, 16'd25}) begin
            errs++; $display("FAIL frozen_hold: got st=%0d first=%b ts=%0d want 5/0100/25", oState, oFirstCh, oTimestamp);
        end
    endtask

    task automatic test_clear();
        iClrReq = 1'b1;
        step();
        iClrReq = 1'b0;
        vecs++;
        if ({oClrAck, oState, oClear_n, oFrozen, oFirstCh, oTimestamp} !== {1'b1, 3'd1, 1'b0, 1'b0, 4'b0, 16'd0}) begin
            errs++; $display("FAIL clear_ack: got ack=%b st=%0d clrn=%b frz=%b first=%b ts=%0d want 1/1/0/0/0/0",
                             oClrAck, oState, oClear_n, oFrozen, oFirstCh, oTimestamp);
        end
        step();
        vecs++;
        if ({oClrAck, oState, oClear_n} !== {1'b0, 3'd2, 1'b1}) begin
            errs++; $display("FAIL clear_done: got ack=%b st=%0d clrn=%b want 0/2/1", oClrAck, oState, oClear_n);
        end
        for (int i = 0; i < AD - 1; i++) step();
        vecs++;
        if ({oState, oEnable} !== {3'd2, 1'b0}) begin
            errs++; $display("FAIL rearm_early: got st=%0d en=%b want 2/0", oState, oEnable);
        end
        step();
        vecs++;
        if ({oState, oEnable} !== {3'd3, 1'b1}) begin
            errs++; $display("FAIL rearm: got st=%0d en=%b want 3/1", oState, oEnable);
        end
    endtask

    task automatic test_priority();
        iArm = 1'b0; iChange = 4'b0011;
        step();
        iChange = '0;
        vecs++;
        if ({oState, oFirstCh} !== {3'd4, 4'b0011}) begin
            errs++; $display("FAIL cap_priority: got st=%0d first=%b want 4/0011", oState, oFirstCh);
        end
        for (int i = 0; i < HC; i++) step();
        vecs++;
        if (oState !== 3'd5) begin
            errs++; $display("FAIL hold_ignores_arm: got st=%0d want 5", oState);
        end
        // held clear level: ack, skipped in CLEAR, re-ack in SETTLE
        iClrReq = 1'b1;
        step();
        vecs++;
        if ({oClrAck, oState} !== {1'b1, 3'd1}) begin
            errs++; $display("FAIL lvl_ack1: got ack=%b st=%0d want 1/1", oClrAck, oState);
        end
        step();
        vecs++;
        if ({oClrAck, oState} !== {1'b0, 3'd2}) begin
            errs++; $display("FAIL lvl_noack: got ack=%b st=%0d want 0/2", oClrAck, oState);
        end
        step();
        vecs++;
        if ({oClrAck, oState} !== {1'b1, 3'd1}) begin
            errs++; $display("FAIL lvl_ack2: got ack=%b st=%0d want 1/1", oClrAck, oState);
        end
        iClrReq = 1'b0;
        step();
        step();
        vecs++;
        if (oState !== 3'd0) begin
            errs++; $display("FAIL settle_drop: got st=%0d want 0", oState);
        end
        iClrReq = 1'b1;
        step();
        iClrReq = 1'b0;
        vecs++;
        if ({oClrAck, oState} !== {1'b1, 3'd0}) begin
            errs++; $display("FAIL idle_ack: got ack=%b st=%0d want 1/0", oClrAck, oState);
        end
    endtask

    task automatic test_settle_abort();
        logic saw_en;
        do_reset();
        saw_en = 1'b0;
        iArm = 1'b1;
        for (int i = 0; i < 6; i++) begin step(); saw_en |= oEnable; end
        iArm = 1'b0;
        step();
        saw_en |= oEnable;
        vecs++;
        if (oState !== 3'd0) begin
            errs++; $display("FAIL abort_idle: got st=%0d want 0", oState);
        end
        for (int i = 0; i < 12; i++) begin step(); saw_en |= oEnable; end
        vecs++;
        if (saw_en !== 1'b0) begin
            errs++; $display("FAIL abort_enable: got en_seen=%b want 0", saw_en);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        go_armed();
        for (int i = 0; i < 40; i++) step();
        iChange = 4'b0001;
        step();
        iChange = '0;
        vecs++;
        if ({oTimestamp, t4_ts, t4_state} !== {16'd40, 4'd15, 3'd4}) begin
            errs++; $display("FAIL saturate: got ts16=%0d ts4=%0d st4=%0d want 40/15/4", oTimestamp, t4_ts, t4_state);
        end
    endtask

    task automatic test_second();
        logic [CH-1:0] exp_sec;
        logic [TSB-1:0] exp_sts;
`ifdef STATE_LOG_SECOND_FAULT_EN
        exp_sec = 4'b0010; exp_sts = 16'd12;
`else
        exp_sec = 4'b0000; exp_sts = 16'd0;
`endif
        do_reset();
        go_armed();
        for (int i = 0; i < 10; i++) step();
        iChange = 4'b0001; step();
        iChange = 4'b0000; step();
        iChange = 4'b0011; step();
        vecs++;
        if ({oSecondCh, oSecondTs} !== {exp_sec, exp_sts}) begin
            errs++; $display("FAIL second_latch: got ch=%b ts=%0d want %b/%0d", oSecondCh, oSecondTs, exp_sec, exp_sts);
        end
        iChange = 4'b0100; step();
        iChange = 4'b0000; step();
        vecs++;
        if ({oState, oFirstCh, oTimestamp, oSecondCh, oSecondTs} !== {3'd5, 4'b0001, 16'd10, exp_sec, exp_sts}) begin
            errs++; $display("FAIL second_hold: got st=%0d first=%b ts=%0d ch=%b sts=%0d want 5/0001/10/%b/%0d",
                             oState, oFirstCh, oTimestamp, oSecondCh, oSecondTs, exp_sec, exp_sts);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge iClk);
        iRst_n = 1'b0;
        #1;
        vecs++;
        if ({oState, oClear_n, oEnable, oFirstCh, oTimestamp, oFrozen, oClrAck, oSecondCh, oSecondTs} !== '0) begin
            errs++; $display("FAIL reset_mid: got st=%0d first=%b ts=%0d frz=%b sec=%b want all 0",
                             oState, oFirstCh, oTimestamp, oFrozen, oSecondCh);
        end
        do_reset();
    endtask

    task automatic test_random();
        logic [46:0] act, exp;
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            iArm    = ($urandom_range(0, 99) < 95);
            iClrReq = ($urandom_range(0, 99) < 2);
            iChange = ($urandom_range(0, 99) < 5) ? CH'($urandom_range(1, 15)) : '0;
            step();
            act = {oState, oClear_n, oEnable, oFirstCh, oTimestamp, oFrozen, oClrAck, oSecondCh, oSecondTs};
            exp = {3'(m_st), (m_st > 1), (m_st == 3 || m_st == 4), m_first, 16'(m_fts),
                   (m_st == 5), m_ack, m_sec, 16'(m_sts)};
            vecs++;
            if (act !== exp) begin
                errs++;
                $display("FAIL random[%0d]: got %h want %h (st %0d vs %0d)", n, act, exp, oState, m_st);
            end
        end
    endtask

    initial begin
        test_reset();
        test_arm_seq();
        test_capture();
        test_clear();
        test_priority();
        test_settle_abort();
        test_saturate();
        test_second();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/state_log_sequencer.md
Name: state_log_sequencer

Overview:
Sequences a bank of CHANNELS single-reference state loggers through one arm/capture/freeze cycle. It drives the loggers' shared active-low clear and enable, and watches each channel's nonzero-change flag. It latches which channels changed first and a timestamp of that event, then freezes the logs until the BMC requests a clear. It sits between the power-sequencing FSM (arm source) and the logger instances.

Parameters:
CHANNELS, 4, number of logger channels monitored
TS_BITS, 16, width of the saturating timestamp counter
ARM_DLY, 8, cycles spent in SETTLE before enabling loggers (≥1)
HOLD_CYC, 4, cycles the loggers stay enabled after the first capture, so collateral changes are recorded (≥0)

Ports:
iClk  input  1  clock
iRst_n  input  1  reset, asynchronous, active-low
iArm  input  1  power sequence at steady state; logging may arm
iClrReq  input  1  BMC clear request, level; sampled each cycle
iChange  input  CHANNELS  per-channel flag: logger ochange is nonzero
oClear_n  output  1  active-low clear to all loggers
oEnable  output  1  enable to all loggers
oFirstCh  output  CHANNELS  iChange snapshot at first capture
oTimestamp  output  TS_BITS  timestamp at first capture
oFrozen  output  1  log frozen, valid for readout
oClrAck  output  1  one-cycle acknowledge of an accepted clear
oState  output  3  FSM state encoding, for debug
oSecondCh  output  CHANNELS  see Optional Feature
oSecondTs  output  TS_BITS  see Optional Feature

Behaviour:
- Reset values: state IDLE, oClear_n=0, oEnable=0, oFirstCh=0, oTimestamp=0, oFrozen=0, oClrAck=0, oSecondCh=0, oSecondTs=0, timestamp and delay counters 0.
- All outputs are registered. The next-state decision uses inputs sampled at the rising edge.
- State encodings: IDLE=0, CLEAR=1, SETTLE=2, ARMED=3, HOLD=4, FROZEN=5. Encodings 6 and 7 go to IDLE.
- IDLE: oClear_n=0, oEnable=0. iArm=1 -> CLEAR.
- CLEAR: lasts exactly 1 cycle with oClear_n=0. Zeroes oFirstCh, oTimestamp, oSecondCh, oSecondTs and the timestamp counter. Then -> SETTLE.
- SETTLE: oClear_n=1, oEnable=0. The delay counter runs ARM_DLY cycles, then -> ARMED. iArm=0 -> IDLE.
- ARMED:
  - oEnable=1. The timestamp is 0 in the first ARMED cycle and increments each cycle, saturating at 2^TS_BITS-1 with no wrap.
  - If iChange≠0: latch oFirstCh=iChange and oTimestamp=current timestamp, then -> HOLD.
  - Otherwise, iArm=0 -> IDLE.
  - Capture has priority over iArm=0 in the same cycle.
- HOLD: oEnable=1 for HOLD_CYC cycles. The timestamp keeps counting, and iArm is ignored. Then -> FROZEN. With HOLD_CYC=0, go straight to FROZEN on the next cycle.
- FROZEN: oEnable=0, oClear_n=1, oFrozen=1. Captured values are held. iArm is ignored.
- iClrReq handling:
  - In FROZEN, ARMED, SETTLE or HOLD: assert oClrAck for 1 cycle and go -> CLEAR. oFrozen drops the same cycle.
  - In IDLE: oClrAck pulses and the state stays IDLE.
  - In CLEAR: no ack. The request is re-sampled next cycle.
  - A level held high re-acks every time the FSM returns to a state that accepts a clear.
- Reset mid-operation: immediate return to reset values. Captured data is lost.

Optional Feature:
- Macro: STATE_LOG_SECOND_FAULT_EN.
- With the macro defined:
  - During HOLD, the first cycle where (iChange & ~oFirstCh)≠0 latches oSecondCh=(iChange & ~oFirstCh) and oSecondTs=current timestamp.
  - Later changes in HOLD do not overwrite them.
  - The values are held through FROZEN and cleared in CLEAR.
- Without the macro: oSecondCh and oSecondTs are constant 0. The ports remain, so the interface stays stable.

Test Plan:
- Use CHANNELS=4, ARM_DLY=8, HOLD_CYC=4, TS_BITS=16 unless stated otherwise.
1. Release reset, then iArm=1 at cycle 0 -> oClear_n=0 during the CLEAR cycle, oEnable=1 starting 1+8 cycles after CLEAR entry, oState sequence 1,2,3.
2. In ARMED, drive iChange=4'b0100 in the cycle where the timestamp is 25 -> oFirstCh=0100 and oTimestamp=25. oEnable stays 1 for 4 more cycles, then oFrozen=1 and oEnable=0.
3. In ARMED, drive iChange=4'b0011 and iArm=0 in the same cycle -> state goes to HOLD (not IDLE), with oFirstCh=0011.
4. In FROZEN, pulse iClrReq for 1 cycle -> oClrAck=1 for one cycle, then oClear_n=0 for one cycle, captures read 0, and with iArm=1 the block re-arms after 8 cycles.
5. Drop iArm at SETTLE cycle 5 -> IDLE, and oEnable is never asserted. Separately, with TS_BITS=4 and a change at ARMED cycle 40 -> oTimestamp=15.
6. With STATE_LOG_SECOND_FAULT_EN defined, iChange=0001 at ts=10 and then 0011 at ts=12 -> oSecondCh=0010, oSecondTs=12. Without the macro, both outputs read 0.
